// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle data memory responder.
package mem_pkg;

    localparam int unsigned WordWidth      = 32;
    localparam int unsigned DefaultDepth   = 256;
    localparam int unsigned DefaultLatency = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/datamem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, never cleared.
module datamem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [IdxW-1:0]      addr_i,
    input  logic [WordWidth-1:0] wdata_i,
    output logic [WordWidth-1:0] rdata_o
);

    logic [WordWidth-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/datamem_responder.sv
// Load/store target with a fixed wait of LATENCY cycles per access and a
// one-cycle ack pulse; out-of-range word addresses complete with err=1.
module datamem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned LATENCY = DefaultLatency
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [WordWidth-1:0] addr,
    input  logic [WordWidth-1:0] wdata,
    output logic                 ack,
    output logic [WordWidth-1:0] rdata,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WordWidth-1:0] addr_q, addr_d;
    logic [WordWidth-1:0] wdata_q, wdata_d;
    logic                 ack_q, ack_d;
    logic [WordWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 in_range;
    logic                 access_now;
    logic                 mem_we;
    logic [WordWidth-1:0] mem_rdata;

    // Upper address bits only feed this check; the array sees the low index bits.
    assign in_range   = (addr_q < DEPTH);
    assign access_now = (state_q == StWait) && (cnt_q == CntW'(1));
    assign mem_we     = access_now && we_q && in_range;

    datamem_array #(
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q[IdxW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CntW'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (access_now) begin
                    state_d = StResp;
                    ack_d   = 1'b1;
                    err_d   = ~in_range;
                    rdata_d = (!we_q && in_range) ? mem_rdata : '0;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

endmodule
